// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM ramp controller: register map,
// FSM state encoding and the duty stepping helper.
package pwm_ctrl_pkg;

  localparam logic [6:0] ADDR_EN_OUT_7_0   = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8  = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0   = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8  = 7'h03;
  localparam logic [6:0] ADDR_DUTY         = 7'h04;
  localparam logic [6:0] ADDR_TARGET       = 7'h05;
  localparam logic [6:0] ADDR_STEP         = 7'h06;
  localparam logic [6:0] ADDR_INTERVAL     = 7'h07;

  localparam logic [7:0] STEP_RESET_VALUE  = 8'd1;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_t;

  // Moves cur toward tgt by stp (a zero step counts as one), landing
  // exactly on tgt instead of passing it or wrapping around 8 bits.
  function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] stp);
    logic [8:0] eff;
    logic [8:0] sum;
    logic [8:0] gap;
    logic [7:0] result;
    eff    = {1'b0, (stp == 8'd0) ? 8'd1 : stp};
    sum    = {1'b0, cur} + eff;
    gap    = {1'b0, cur} - {1'b0, tgt};
    result = cur;
    if (cur < tgt) begin
      if (sum >= {1'b0, tgt}) begin
        result = tgt;
      end else begin
        result = sum[7:0];
      end
    end else if (cur > tgt) begin
      if (eff >= gap) begin
        result = tgt;
      end else begin
        result = cur - eff[7:0];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/pwm_tick_counter.sv
// Loadable down-counter that paces the duty ramp; zero marks the end
// of one ramp interval.
module pwm_tick_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load takes priority over decrement; the count never goes below zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Register block and duty ramp engine sitting between the SPI register
// interface and the PWM peripheral.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       ramp_busy,
  output logic       ramp_done
);

  localparam int TICK_SHIFT = $clog2(TICK_DIV);
  localparam int CNT_W      = 8 + TICK_SHIFT;

  ramp_state_t state, state_next;

  logic [7:0] en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi;
  logic [7:0] step_reg, interval_reg;
  logic [7:0] duty, duty_next;
  logic [7:0] target, target_next;
  logic       done_next;
  logic       cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] reload_value;
  logic [7:0] stepped_duty;
  logic       wr_duty, wr_target;

  assign wr_duty   = wr_valid && (wr_addr == ADDR_DUTY);
  assign wr_target = wr_valid && (wr_addr == ADDR_TARGET);

  assign reload_value = ({{TICK_SHIFT{1'b0}}, interval_reg} << TICK_SHIFT)
                      | CNT_W'(TICK_DIV - 1);

  assign stepped_duty = step_toward(duty, target, step_reg);

  pwm_tick_counter #(
    .WIDTH(CNT_W)
  ) u_tick_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .load_value(reload_value),
    .dec       (cnt_dec),
    .zero      (cnt_zero)
  );

  // Enable registers are plain storage mirrored straight to the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_out_lo <= 8'd0;
      en_out_hi <= 8'd0;
      en_pwm_lo <= 8'd0;
      en_pwm_hi <= 8'd0;
    end else if (wr_valid) begin
      case (wr_addr)
        ADDR_EN_OUT_7_0:  en_out_lo <= wr_data;
        ADDR_EN_OUT_15_8: en_out_hi <= wr_data;
        ADDR_EN_PWM_7_0:  en_pwm_lo <= wr_data;
        ADDR_EN_PWM_15_8: en_pwm_hi <= wr_data;
        default: ;
      endcase
    end
  end

  // Step and interval are only sampled at counter reload, so mid-ramp
  // writes take effect at the next interval boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_reg     <= STEP_RESET_VALUE;
      interval_reg <= 8'd0;
    end else if (wr_valid) begin
      case (wr_addr)
        ADDR_STEP:     step_reg     <= wr_data;
        ADDR_INTERVAL: interval_reg <= wr_data;
        default: ;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, next-duty and counter control for the ramp engine.
  always_comb begin
    state_next  = state;
    duty_next   = duty;
    target_next = target;
    done_next   = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    case (state)
      IDLE: begin
        if (wr_duty) begin
          duty_next   = wr_data;
          target_next = wr_data;
        end else if (wr_target) begin
          target_next = wr_data;
          if (wr_data != duty) begin
            state_next = RAMP;
            cnt_load   = 1'b1;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      RAMP: begin
        if (wr_duty) begin
          duty_next   = wr_data;
          target_next = wr_data;
          state_next  = IDLE;
        end else if (wr_target) begin
          target_next = wr_data;
          cnt_load    = 1'b1;
        end else if (duty == target) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (cnt_zero) begin
          duty_next = stepped_duty;
          cnt_load  = 1'b1;
          if (stepped_duty == target) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Duty, target and the one-cycle completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty      <= 8'd0;
      target    <= 8'd0;
      ramp_done <= 1'b0;
    end else begin
      duty      <= duty_next;
      target    <= target_next;
      ramp_done <= done_next;
    end
  end

  assign en_reg_out_7_0  = en_out_lo;
  assign en_reg_out_15_8 = en_out_hi;
  assign en_reg_pwm_7_0  = en_pwm_lo;
  assign en_reg_pwm_15_8 = en_pwm_hi;
  assign pwm_duty_cycle  = duty;
  assign ramp_busy       = (state == RAMP);

endmodule
